// File: rtl/xbus_pkg.sv
// Shared XBus definitions: bus widths, phase FSM encoding and the size-to-beat mapping.
package xbus_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned SIZE_W     = 2;
  localparam int unsigned BEAT_CNT_W = 3;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } xbus_state_t;

  // Encoded size to (beats - 1): 0->0, 1->1, 2->3, 3->7.
  function automatic logic [BEAT_CNT_W-1:0] beats_m1(input logic [SIZE_W-1:0] size);
    logic [BEAT_CNT_W:0] beats;
    beats = (BEAT_CNT_W+1)'(1) << size;
    return BEAT_CNT_W'(beats - (BEAT_CNT_W+1)'(1));
  endfunction

endpackage

// File: rtl/xbus_arbiter_ctrl_if.sv
// XBus signal bundle; the controller uses the master modport, bus agents the slave modport.
interface xbus_arbiter_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = xbus_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = xbus_pkg::DATA_WIDTH
);

  logic                  xbus_req_master_0;
  logic                  xbus_gnt_master_0;
  logic                  xbus_req_master_1;
  logic                  xbus_gnt_master_1;
  logic [ADDR_WIDTH-1:0] xbus_addr;
  logic [1:0]            xbus_size;
  logic                  xbus_read;
  logic                  xbus_write;
  logic                  xbus_start;
  logic                  xbus_bip;
  logic [DATA_WIDTH-1:0] xbus_data;
  logic                  xbus_wait;
  logic                  xbus_error;

  modport master (
    input  xbus_req_master_0, xbus_req_master_1,
    input  xbus_addr, xbus_size, xbus_read, xbus_write,
    input  xbus_bip, xbus_data, xbus_wait, xbus_error,
    output xbus_gnt_master_0, xbus_gnt_master_1, xbus_start
  );

  modport slave (
    output xbus_req_master_0, xbus_req_master_1,
    output xbus_addr, xbus_size, xbus_read, xbus_write,
    output xbus_bip, xbus_data, xbus_wait, xbus_error,
    input  xbus_gnt_master_0, xbus_gnt_master_1, xbus_start
  );

endinterface

// File: rtl/xbus_prio_arbiter.sv
// Fixed-priority request-to-grant map; master 0 always wins.
module xbus_prio_arbiter (
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  always_comb begin
    gnt_c = 2'b00;
    if (req[0])      gnt_c = 2'b01;
    else if (req[1]) gnt_c = 2'b10;
  end

endmodule

// File: rtl/xbus_arbiter_ctrl.sv
// XBus central controller: runs ARB/ADDR/DATA phases, drives start and grants,
// and counts data beats so the next arbitration follows the last beat directly.
module xbus_arbiter_ctrl
  import xbus_pkg::*;
(
  input  logic              xbus_clock,
  input  logic              xbus_reset,
  xbus_arbiter_ctrl_if.master bus
);

  xbus_state_t           state_q, state_d;
  logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  started_q, started_d;
  logic                  start_q, start_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            arb_gnt_c;
  logic                  unused_obs;

  // Address and data are visible to the controller but never steer it.
  assign unused_obs = ^{bus.xbus_addr, bus.xbus_data};

  xbus_prio_arbiter u_prio (
    .req   ({bus.xbus_req_master_1, bus.xbus_req_master_0}),
    .gnt_c (arb_gnt_c)
  );

  // State register; started_q makes the first edge after reset an ARB cycle.
  always_ff @(posedge xbus_clock or posedge xbus_reset) begin
    if (xbus_reset) begin
      state_q   <= ARB;
      cnt_q     <= '0;
      started_q <= 1'b0;
      start_q   <= 1'b0;
      gnt_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
      start_q   <= start_d;
      gnt_q     <= gnt_d;
    end
  end

  // Next-state, beat counter and next registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    started_d = 1'b1;
    gnt_d     = 2'b00;

    if (!started_q) begin
      state_d = ARB;
    end else begin
      case (state_q)
        ARB: begin
          state_d = ADDR;
          gnt_d   = arb_gnt_c;
        end
        ADDR: begin
          // read and write together is illegal and handled as a NOP.
          if ((|gnt_q) && (bus.xbus_read ^ bus.xbus_write)) begin
            state_d = DATA;
            cnt_d   = beats_m1(bus.xbus_size);
          end else begin
            state_d = ARB;
          end
        end
        DATA: begin
          if (bus.xbus_error) begin
            state_d = ARB;
          end else if (!bus.xbus_wait) begin
            if ((cnt_q == '0) || !bus.xbus_bip) state_d = ARB;
            else                                 cnt_d   = cnt_q - BEAT_CNT_W'(1);
          end
        end
        default: state_d = ARB;
      endcase
    end

    start_d = (state_d == ARB);
  end

  assign bus.xbus_start        = start_q;
  assign bus.xbus_gnt_master_0 = gnt_q[0];
  assign bus.xbus_gnt_master_1 = gnt_q[1];

endmodule

// File: tb/tb_xbus_arbiter_ctrl.sv
// Self-checking bench for xbus_arbiter_ctrl: directed phases plus random transfers
// checked against a per-transfer expectation of start/grant activity.
module tb_xbus_arbiter_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  xbus_arbiter_ctrl_if bus ();

  xbus_arbiter_ctrl dut (
    .xbus_clock (clk),
    .xbus_reset (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] outs();
    return {bus.xbus_start, bus.xbus_gnt_master_1, bus.xbus_gnt_master_0};
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed {start,gnt1,gnt0}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.xbus_req_master_0 = 1'b0;
    bus.xbus_req_master_1 = 1'b0;
    bus.xbus_addr         = '0;
    bus.xbus_size         = 2'd0;
    bus.xbus_read         = 1'b0;
    bus.xbus_write        = 1'b0;
    bus.xbus_bip          = 1'b0;
    bus.xbus_data         = '0;
    bus.xbus_wait         = 1'b0;
    bus.xbus_error        = 1'b0;
  endtask

  // One bus tenure starting at an ARB cycle. waits holds 2 bits of wait
  // cycles per beat; err_beat / bip_beat >= beats means "never".
  task automatic run_txn(input string tag, input bit r0, input bit r1,
                         input bit rd, input bit wr, input logic [1:0] sz,
                         input logic [15:0] waits, input int err_beat, input int bip_beat);
    int beats;
    int last;
    int nw;
    bit done;
    logic [2:0] exp_gnt;

    @(negedge clk);
    chk({tag, ":arb"}, outs(), 3'b100);
    bus.xbus_req_master_0 = r0;
    bus.xbus_req_master_1 = r1;
    bus.xbus_wait         = 1'b0;
    bus.xbus_error        = 1'b0;
    bus.xbus_bip          = 1'b0;

    @(negedge clk);
    exp_gnt = r0 ? 3'b001 : (r1 ? 3'b010 : 3'b000);
    chk({tag, ":addr"}, outs(), exp_gnt);
    bus.xbus_read  = rd;
    bus.xbus_write = wr;
    bus.xbus_size  = sz;
    bus.xbus_addr  = 16'($urandom);

    if ((r0 || r1) && (rd ^ wr)) begin
      beats = 1 << sz;
      last  = (bip_beat < beats) ? bip_beat : beats - 1;
      done  = 1'b0;
      for (int b = 0; b <= last && !done; b++) begin
        nw = int'(waits[2*b +: 2]);
        for (int w = 0; w <= nw && !done; w++) begin
          @(negedge clk);
          chk({tag, ":data"}, outs(), 3'b000);
          bus.xbus_read  = 1'b0;
          bus.xbus_write = 1'b0;
          bus.xbus_data  = 8'($urandom);
          bus.xbus_wait  = (w < nw);
          bus.xbus_bip   = (b != last);
          bus.xbus_error = (b == err_beat) && (w == 0);
          if (bus.xbus_error) done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic [15:0] rw;
    bit r0, r1, rd, wr;
    int eb, bb;

    n_checks = 0;
    n_err    = 0;
    clear_inputs();
    rst = 1'b1;

    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", outs(), 3'b000);
    end
    #21 rst = 1'b0;

    // Idle bus: start toggles 1,0.
    run_txn("idle0", 0, 0, 0, 0, 2'd0, 16'h0, 99, 99);
    run_txn("idle1", 0, 0, 0, 0, 2'd0, 16'h0, 99, 99);

    run_txn("m0_wr1", 1, 0, 0, 1, 2'd0, 16'h0, 99, 99);
    run_txn("both_rd2", 1, 1, 1, 0, 2'd1, 16'h0, 99, 99);
    run_txn("both_nop", 1, 1, 0, 0, 2'd0, 16'h0, 99, 99);
    run_txn("both_wr1", 1, 1, 0, 1, 2'd0, 16'h0, 99, 99);
    run_txn("m1_rd4_wait", 0, 1, 1, 0, 2'd2, 16'h000C, 99, 99);
    run_txn("m0_wr8_err", 1, 0, 0, 1, 2'd3, 16'h0, 2, 99);
    run_txn("m1_rdwr_illegal", 0, 1, 1, 1, 2'd3, 16'h0, 99, 99);
    run_txn("m0_wr8_bip_early", 1, 0, 0, 1, 2'd3, 16'h0, 99, 4);
    run_txn("m1_err_in_wait", 0, 1, 1, 0, 2'd2, 16'h00C0, 3, 99);

    // Reset during DATA, held across an edge, then restart in ARB.
    @(negedge clk);
    chk("rst_data:arb", outs(), 3'b100);
    bus.xbus_req_master_0 = 1'b1;
    @(negedge clk);
    chk("rst_data:addr", outs(), 3'b001);
    bus.xbus_write = 1'b1;
    bus.xbus_size  = 2'd3;
    @(negedge clk);
    chk("rst_data:data", outs(), 3'b000);
    bus.xbus_wait = 1'b1;
    bus.xbus_bip  = 1'b1;
    #2 rst = 1'b1;
    #1 chk("rst_data:async", outs(), 3'b000);
    @(negedge clk);
    chk("rst_data:held", outs(), 3'b000);
    clear_inputs();
    #1 rst = 1'b0;

    // Reset during ADDR must drop the live grant asynchronously.
    @(negedge clk);
    chk("rst_addr:arb", outs(), 3'b100);
    bus.xbus_req_master_1 = 1'b1;
    @(negedge clk);
    chk("rst_addr:addr", outs(), 3'b010);
    #2 rst = 1'b1;
    #1 chk("rst_addr:async", outs(), 3'b000);
    @(negedge clk);
    clear_inputs();
    #1 rst = 1'b0;

    // Reset during ARB must drop start asynchronously.
    @(negedge clk);
    chk("rst_arb:arb", outs(), 3'b100);
    #2 rst = 1'b1;
    #1 chk("rst_arb:async", outs(), 3'b000);
    @(negedge clk);
    #1 rst = 1'b0;

    run_txn("post_rst", 0, 1, 0, 1, 2'd1, 16'h0001, 99, 99);

    for (int i = 0; i < 60; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      rw = '0;
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 3) == 0) rw[2*b +: 2] = 2'($urandom_range(1, 3));
      eb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : 99;
      bb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : 99;
      run_txn("rand", r0, r1, rd, wr, 2'($urandom_range(0, 3)), rw, eb, bb);
    end

    // Closing ARB cycle confirms the last random tenure ended on time.
    run_txn("final", 0, 0, 0, 0, 2'd0, 16'h0, 99, 99);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
